alu_6bit: RTL and testbench



---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_datapath.sv | 50 +++++
 rtl/alu_6bit.sv | 61 ++++++
 tb/tb_alu_6bit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and default geometry for the registered ALU.
package alu_pkg;
  localparam int DEF_WIDTH = 6;
  localparam int DEF_SHIFT = 3;
  localparam logic [3:0] OP_ZERO   = 4'b0000;
  localparam logic [3:0] OP_PASS_A = 4'b0001;
  localparam logic [3:0] OP_PASS_B = 4'b0010;
  localparam logic [3:0] OP_GE     = 4'b0011;
  localparam logic [3:0] OP_NEG_A  = 4'b0100;
  localparam logic [3:0] OP_NEG_B  = 4'b0101;
  localparam logic [3:0] OP_SHR_A  = 4'b0110;
  localparam logic [3:0] OP_SHR_B  = 4'b0111;
  localparam logic [3:0] OP_XOR    = 4'b1000;
  localparam logic [3:0] OP_NOT_A  = 4'b1001;
  localparam logic [3:0] OP_NOT_B  = 4'b1010;
  localparam logic [3:0] OP_SUB    = 4'b1011;
  localparam logic [3:0] OP_ADD    = 4'b1100;
  localparam logic [3:0] OP_ONES   = 4'b1111;
endpackage

// File: rtl/alu_datapath.sv
// alu_datapath: combinational opcode decode and result/flag generation; ALU_FLAGS_EN adds carry/overflow outputs.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SHIFT_AMT = DEF_SHIFT
) (
  input  logic [3:0]       sel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o
`ifdef ALU_FLAGS_EN
  ,
  output logic             c_o,
  output logic             v_o
`endif
);
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   diff;
  assign diff = {1'b0, a_i} - {1'b0, b_i};
`ifdef ALU_FLAGS_EN
  logic c_add;
  assign {c_add, sum} = {1'b0, a_i} + {1'b0, b_i};
  assign c_o = (sel_i == OP_ADD) ? c_add : (sel_i == OP_SUB) ? diff[WIDTH] : 1'b0;
  assign v_o = (sel_i == OP_ADD) ? (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1])
             : (sel_i == OP_SUB) ? (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1])
             : 1'b0;
`else
  assign sum = a_i + b_i;
`endif
  always_comb begin
    res_o = '0;
    case (sel_i)
      OP_PASS_A: res_o = a_i;
      OP_PASS_B: res_o = b_i;
      OP_GE:     res_o = {{(WIDTH-1){1'b0}}, ~diff[WIDTH]};
      OP_NEG_A:  res_o = -a_i;
      OP_NEG_B:  res_o = -b_i;
      OP_SHR_A:  res_o = a_i >> SHIFT_AMT;
      OP_SHR_B:  res_o = b_i >> SHIFT_AMT;
      OP_XOR:    res_o = a_i ^ b_i;
      OP_NOT_A:  res_o = ~a_i;
      OP_NOT_B:  res_o = ~b_i;
      OP_SUB:    res_o = diff[WIDTH-1:0];
      OP_ADD:    res_o = sum;
      OP_ONES:   res_o = '1;
      default:   res_o = '0;
    endcase
  end
endmodule

// File: rtl/alu_6bit.sv
// alu_6bit: registered ALU with async active-low reset; ALU_FLAGS_EN adds registered z/n/c/v flags.
module alu_6bit
  import alu_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SHIFT_AMT = DEF_SHIFT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] X
`ifdef ALU_FLAGS_EN
  ,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
`endif
);
  logic [WIDTH-1:0] x_d, x_q;
`ifdef ALU_FLAGS_EN
  logic c_d, v_d, z_q, n_q, c_q, v_q;
`endif
  alu_datapath #(.WIDTH(WIDTH), .SHIFT_AMT(SHIFT_AMT)) u_dp (
    .sel_i (sel),
    .a_i   (A),
    .b_i   (B),
    .res_o (x_d)
`ifdef ALU_FLAGS_EN
    ,
    .c_o   (c_d),
    .v_o   (v_d)
`endif
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) x_q <= '0;
    else        x_q <= x_d;
  end
  assign X = x_q;
`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      z_q <= (x_d == '0);
      n_q <= x_d[WIDTH-1];
      c_q <= c_d;
      v_q <= v_d;
    end
  end
  assign flag_z = z_q;
  assign flag_n = n_q;
  assign flag_c = c_q;
  assign flag_v = v_q;
`endif
endmodule

// File: tb/tb_alu_6bit.sv
// tb_alu_6bit: scoreboard bench for alu_6bit (flag checks included when ALU_FLAGS_EN is defined).
module tb_alu_6bit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] sel = '0;
  logic [5:0] A = '0;
  logic [5:0] B = '0;
  logic [5:0] X;
`ifdef ALU_FLAGS_EN
  logic flag_z, flag_n, flag_c, flag_v;
`endif
  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] exp_q[$];

  alu_6bit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel    (sel),
    .A      (A),
    .B      (B),
    .X      (X)
`ifdef ALU_FLAGS_EN
    ,
    .flag_z (flag_z),
    .flag_n (flag_n),
    .flag_c (flag_c),
    .flag_v (flag_v)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] model(logic [3:0] s, logic [5:0] a, logic [5:0] b);
    int ai, bi, r;
    ai = int'(a);
    bi = int'(b);
    case (s)
      4'd1:    r = ai;
      4'd2:    r = bi;
      4'd3:    r = (ai >= bi) ? 1 : 0;
      4'd4:    r = 64 - ai;
      4'd5:    r = 64 - bi;
      4'd6:    r = ai / 8;
      4'd7:    r = bi / 8;
      4'd8:    r = int'(a ^ b);
      4'd9:    r = 63 - ai;
      4'd10:   r = 63 - bi;
      4'd11:   r = ai - bi + 64;
      4'd12:   r = ai + bi;
      4'd15:   r = 63;
      default: r = 0;
    endcase
    return 6'(r % 64);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    sel = 4'b1111; A = '0; B = '0;
    @(posedge clk); #1;
    n_cmp++;
    if (X !== 6'b111111) begin n_err++; $display("FAIL pre_reset: X=%b want=%b", X, 6'b111111); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (X !== 6'b000000) begin n_err++; $display("FAIL async_reset: X=%b want=%b", X, 6'b000000); end
    @(posedge clk); #1;
    n_cmp++;
    if (X !== 6'b000000) begin n_err++; $display("FAIL reset_hold: X=%b want=%b", X, 6'b000000); end
    @(negedge clk);
    rst_n = 1'b1; sel = 4'b0001; A = 6'b101010;
    #1;
    n_cmp++;
    if (X !== 6'b000000) begin n_err++; $display("FAIL release_no_edge: X=%b want=%b", X, 6'b000000); end
    @(posedge clk); #1;
    n_cmp++;
    if (X !== 6'b101010) begin n_err++; $display("FAIL first_after_reset: X=%b want=%b", X, 6'b101010); end
  endtask

  task automatic test_ops();
    logic [3:0] sels[14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                             4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd15};
    logic [5:0] exps[14] = '{6'b000000, 6'b011010, 6'b011100, 6'b000000, 6'b100110,
                             6'b100100, 6'b000011, 6'b000011, 6'b000110, 6'b100101,
                             6'b100011, 6'b111110, 6'b110110, 6'b111111};
    logic [5:0] e;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      sel = sels[i]; A = 6'b011010; B = 6'b011100;
      exp_q.push_back(exps[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (X !== e) begin n_err++; $display("FAIL op sel=%b: X=%b want=%b", sels[i], X, e); end
    end
  endtask

  task automatic test_boundary();
    logic [3:0] sels[7] = '{4'b1101, 4'b1110, 4'b0011, 4'b1100, 4'b1011, 4'b0100, 4'b0101};
    logic [5:0] as[7]   = '{6'b011010, 6'b011010, 6'b010101, 6'b111111, 6'b000000, 6'b100000, 6'b000000};
    logic [5:0] bs[7]   = '{6'b011100, 6'b011100, 6'b010101, 6'b000001, 6'b000001, 6'b000000, 6'b100000};
    logic [5:0] exps[7] = '{6'b000000, 6'b000000, 6'b000001, 6'b000000, 6'b111111, 6'b100000, 6'b100000};
    logic [5:0] e;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sel = sels[i]; A = as[i]; B = bs[i];
      exp_q.push_back(exps[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (X !== e) begin n_err++; $display("FAIL boundary sel=%b A=%b B=%b: X=%b want=%b", sels[i], as[i], bs[i], X, e); end
    end
  endtask

`ifdef ALU_FLAGS_EN
  task automatic test_flags();
    @(negedge clk);
    sel = 4'b1100; A = 6'b011010; B = 6'b011100;
    @(posedge clk); #1;
    n_cmp++;
    if ({X, flag_z, flag_n, flag_c, flag_v} !== {6'b110110, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL flags_add: X=%b zncv=%b%b%b%b want X=110110 zncv=0101", X, flag_z, flag_n, flag_c, flag_v);
    end
    @(negedge clk);
    sel = 4'b1011;
    @(posedge clk); #1;
    n_cmp++;
    if ({X, flag_z, flag_n, flag_c, flag_v} !== {6'b111110, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL flags_sub: X=%b zncv=%b%b%b%b want X=111110 zncv=0110", X, flag_z, flag_n, flag_c, flag_v);
    end
    @(negedge clk);
    sel = 4'b0000;
    @(posedge clk); #1;
    n_cmp++;
    if ({X, flag_z, flag_n, flag_c, flag_v} !== {6'b000000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL flags_zero: X=%b zncv=%b%b%b%b want X=000000 zncv=1000", X, flag_z, flag_n, flag_c, flag_v);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [5:0] e;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      sel = 4'($urandom_range(0, 15)); A = 6'($urandom); B = 6'($urandom);
      exp_q.push_back(model(sel, A, B));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (X !== e) begin n_err++; $display("FAIL b2b[%0d] sel=%b A=%b B=%b: X=%b want=%b", i, sel, A, B, X, e); end
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_boundary();
`ifdef ALU_FLAGS_EN
    test_flags();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
